// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: operands are split into STAGES slices, one slice is
// summed per stage and its carry is registered into the next stage. Valid/ready on both sides.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic             w_ready     [STAGES];
    logic             w_src_valid [STAGES];
    logic             w_src_carry [STAGES];
    logic [WIDTH-1:0] w_src_sum   [STAGES];
    logic [WIDTH-1:0] w_src_a     [STAGES];
    logic [WIDTH-1:0] w_src_b     [STAGES];
    logic [WIDTH-1:0] w_nxt_sum   [STAGES];
    logic [SLICE:0]   w_slice     [STAGES];
    logic             w_nxt_ovf;
    logic             w_nxt_zero;

    always_comb begin
        logic v_acc;
        // ready_i = !valid_i || ready_{i+1}, unrolled from the output side
        v_acc = out_ready;
        for (int unsigned i = STAGES; i > 0; i--) begin
            v_acc        = v_acc | ~r_valid[i-1];
            w_ready[i-1] = v_acc;
        end

        w_src_valid[0] = in_valid;
        w_src_carry[0] = sub | cin;
        w_src_sum[0]   = '0;
        w_src_a[0]     = a;
        w_src_b[0]     = sub ? ~b : b;
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_carry[i] = r_carry[i-1];
            w_src_sum[i]   = r_sum[i-1];
            w_src_a[i]     = r_a[i-1];
            w_src_b[i]     = r_b[i-1];
        end

        for (int unsigned i = 0; i < STAGES; i++) begin
            w_slice[i] = {1'b0, w_src_a[i][i*SLICE +: SLICE]}
                       + {1'b0, w_src_b[i][i*SLICE +: SLICE]}
                       + {{SLICE{1'b0}}, w_src_carry[i]};
            w_nxt_sum[i] = w_src_sum[i];
            w_nxt_sum[i][i*SLICE +: SLICE] = w_slice[i][SLICE-1:0];
        end

        w_nxt_ovf  = (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1])
                  && (w_nxt_sum[LAST][WIDTH-1] != w_src_a[LAST][WIDTH-1]);
        w_nxt_zero = (w_nxt_sum[LAST] == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_carry[i] <= 1'b0;
                r_sum[i]   <= '0;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= w_src_valid[i];
                    // Data registers only move with a real transaction; bubbles leave them untouched
                    if (w_src_valid[i]) begin
                        r_carry[i] <= w_slice[i][SLICE];
                        r_sum[i]   <= w_nxt_sum[i];
                        r_a[i]     <= w_src_a[i];
                        r_b[i]     <= w_src_b[i];
                    end
                end
            end
            if (w_ready[LAST] && w_src_valid[LAST]) begin
                r_ovf  <= w_nxt_ovf;
                r_zero <= w_nxt_zero;
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign cout      = r_carry[LAST];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: the driver queues hand-computed results on
// acceptance, an independent monitor checks every presented output against the queue head.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] s;
        logic         co, ov, z;
    } vec_t;

    typedef struct {
        logic [W+2:0] res;
        int           stamp;
    } exp_t;

    vec_t vt [16];
    exp_t sb [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int inflight = 0;
    bit lat_chk = 1'b1;
    bit bp_en = 1'b0;
    bit or_level = 1'b1;

    initial begin
        //          a             b             cin   sub   sum           cout  ovf   zero
        vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vt[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[12] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[14] = '{32'h00000010, 32'h00000003, 1'b0, 1'b1, 32'h0000000D, 1'b1, 1'b0, 1'b0};
        vt[15] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            inflight <= 0;
        else
            inflight <= inflight + ((in_valid && in_ready) ? 1 : 0)
                                 - ((out_valid && out_ready) ? 1 : 0);
    end

    // Sole driver of out_ready: random when backpressure is enabled, else a fixed level
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : or_level;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor
    initial begin
        bit   was_stalled;
        exp_t e;
        was_stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                was_stalled = 1'b0;
            end else begin
                chk("in_ready_rule", 64'(in_ready), 64'(!(inflight == ST && !out_ready)));
                if (was_stalled)
                    chk("hold_valid", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got sum %h with empty scoreboard", sum);
                    end else begin
                        e = sb[0];
                        chk("result{sum,cout,ovf,zero}", 64'({sum, cout, overflow, zero}), 64'(e.res));
                        if (out_ready) begin
                            if (lat_chk)
                                chk("latency", 64'(cyc + 1 - e.stamp), 64'(ST));
                            void'(sb.pop_front());
                        end
                    end
                end
                was_stalled = out_valid && !out_ready;
            end
        end
    end

    task automatic send(input int idx);
        exp_t e;
        a        = vt[idx].a;
        b        = vt[idx].b;
        cin      = vt[idx].cin;
        sub      = vt[idx].sub;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res   = {vt[idx].s, vt[idx].co, vt[idx].ov, vt[idx].z};
                e.stamp = cyc + 1;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: vector %0d never accepted, in_ready %b required 1", idx, in_ready);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sum"},       64'(sum),       64'd0);
        chk({tag, "_flags"},     64'({cout, overflow, zero}), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        #12;
        chk_reset_outputs("por");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed singles, each in an empty pipe
        for (int i = 0; i < 5; i++) begin
            send(i);
            drain();
        end

        // Back-to-back stream with out_ready held high
        for (int i = 0; i < 20; i++) send(i % 16);
        drain();

        // Random backpressure
        lat_chk = 1'b0;
        bp_en   = 1'b1;
        for (int i = 0; i < 16; i++) send((i + 5) % 16);
        drain();
        bp_en   = 1'b0;

        // Reset with transactions in flight and the pipe stalled
        or_level = 1'b0;
        @(posedge clk);
        #2;
        send(6);
        send(7);
        send(8);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        reset_n  = 1'b1;
        or_level = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
